// File: rtl/spi_master_if.sv
// Bundles the host-side frame handshake and the SPI pins of the Remora link master.
interface spi_master_if #(
    parameter int BUFFER_SIZE = 64
);
    logic                   start;
    logic [BUFFER_SIZE-1:0] tx_data;
    logic                   busy;
    logic                   done;
    logic [BUFFER_SIZE-1:0] rx_data;
    logic                   rx_ok;
    logic                   SPI_SCK;
    logic                   SPI_SSEL;
    logic                   SPI_MOSI;
    logic                   SPI_MISO;

    modport master (
        input  start, tx_data, SPI_MISO,
        output busy, done, rx_data, rx_ok, SPI_SCK, SPI_SSEL, SPI_MOSI
    );

    modport slave (
        output start, tx_data, SPI_MISO,
        input  busy, done, rx_data, rx_ok, SPI_SCK, SPI_SSEL, SPI_MOSI
    );
endinterface

// File: rtl/spi_master.sv
// Fixed-length full-duplex SPI mode-0 frame master for the Remora link.
// All SPI pins come straight from registers; MISO passes a 2-FF synchroniser.
module spi_master #(
    parameter int          BUFFER_SIZE = 64,
    parameter logic [31:0] RX_MSGID    = 32'h74697277,
    parameter int          CLK_DIV     = 4,
    parameter int          CS_SETUP    = 4,
    parameter int          CS_HOLD     = 4,
    parameter int          CS_GAP      = 4
) (
    input logic        clk,
    input logic        rst_n,
    spi_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            tmr_q, tmr_d;
    logic [15:0]            bitcnt_q, bitcnt_d;
    logic [BUFFER_SIZE-1:0] tx_sh_q, tx_sh_d;
    logic [BUFFER_SIZE-1:0] rx_sh_q, rx_sh_d;
    logic [BUFFER_SIZE-1:0] rx_data_q, rx_data_d;
    logic                   rx_ok_q, rx_ok_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   sck_q, sck_d;
    logic                   ssel_q, ssel_d;
    logic                   mosi_q, mosi_d;
    logic                   miso_s1_q, miso_s2_q;

    logic                   tmr_end;
    logic [16:0]            bit_nx;
    logic                   more_bits;

    assign tmr_end   = (tmr_q == 16'd0);
    assign bit_nx    = {1'b0, bitcnt_q} + 17'd1;
    assign more_bits = (bit_nx < 17'(BUFFER_SIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            bitcnt_q  <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            rx_ok_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            sck_q     <= 1'b0;
            ssel_q    <= 1'b1;
            mosi_q    <= 1'b0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bitcnt_q  <= bitcnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            rx_ok_q   <= rx_ok_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            sck_q     <= sck_d;
            ssel_q    <= ssel_d;
            mosi_q    <= mosi_d;
            miso_s1_q <= bus.SPI_MISO;
            miso_s2_q <= miso_s1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SETUP;
            SETUP:   if (tmr_end)   state_d = LOW;
            LOW:     if (tmr_end)   state_d = HIGH;
            HIGH:    if (tmr_end)   state_d = more_bits ? LOW : HOLD;
            HOLD:    if (tmr_end)   state_d = GAP;
            GAP:     if (tmr_end)   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        rx_ok_d   = rx_ok_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        sck_d     = sck_q;
        ssel_d    = ssel_q;
        mosi_d    = mosi_q;
        bitcnt_d  = bitcnt_q;

        // Each timed state loads its terminal count on entry and counts down to zero.
        if (state_d != state_q) begin
            case (state_d)
                SETUP:   tmr_d = 16'(CS_SETUP - 1);
                LOW:     tmr_d = 16'(CLK_DIV - 1);
                HIGH:    tmr_d = 16'(CLK_DIV - 1);
                HOLD:    tmr_d = 16'(CS_HOLD - 1);
                GAP:     tmr_d = 16'(CS_GAP - 1);
                default: tmr_d = 16'd0;
            endcase
        end else if (!tmr_end) begin
            tmr_d = tmr_q - 16'd1;
        end else begin
            tmr_d = tmr_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_sh_d  = bus.tx_data;
                    mosi_d   = bus.tx_data[BUFFER_SIZE-1];
                    ssel_d   = 1'b0;
                    busy_d   = 1'b1;
                    bitcnt_d = '0;
                end
            end
            LOW: begin
                if (tmr_end) sck_d = 1'b1;
            end
            HIGH: begin
                if (tmr_end) begin
                    rx_sh_d  = {rx_sh_q[BUFFER_SIZE-2:0], miso_s2_q};
                    sck_d    = 1'b0;
                    bitcnt_d = bit_nx[15:0];
                    if (more_bits) begin
                        tx_sh_d = tx_sh_q << 1;
                        mosi_d  = tx_sh_q[BUFFER_SIZE-2];
                    end else begin
                        mosi_d  = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (tmr_end) begin
                    ssel_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    rx_ok_d   = (rx_sh_q[BUFFER_SIZE-1 -: 32] == RX_MSGID);
                    done_d    = 1'b1;
                end
            end
            GAP: begin
                if (tmr_end) busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_ok    = rx_ok_q;
    assign bus.SPI_SCK  = sck_q;
    assign bus.SPI_SSEL = ssel_q;
    assign bus.SPI_MOSI = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a frame-timeline model predicts every pin each cycle,
// and a bit-level slave model in the bench supplies MISO and records MOSI.
module tb_spi_master;
    localparam int          N     = 64;
    localparam int          CD    = 4;
    localparam int          S     = 4;
    localparam int          H     = 4;
    localparam int          G     = 4;
    localparam int          F     = S + 2*CD*N + H;
    localparam logic [31:0] MSGID = 32'h74697277;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_if #(.BUFFER_SIZE(N)) bus();
    spi_master #(.BUFFER_SIZE(N), .RX_MSGID(MSGID), .CLK_DIV(CD),
                 .CS_SETUP(S), .CS_HOLD(H), .CS_GAP(G)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model: presents the response MSB-first at SSEL fall and on each SCK fall.
    logic [N-1:0] rsp_next = '0;
    logic [N-1:0] sl_bits  = '0;
    logic [N-1:0] mosi_cap = '0;
    int           sl_idx = 0, rises = 0, gap_run = 0, gap_min = 1000;
    bit           seen_frame = 0;
    logic         ssel_prev = 1'b1, sck_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (ssel_prev && !bus.SPI_SSEL) begin
            sl_bits  = rsp_next;
            sl_idx   = 0;
            bus.SPI_MISO = sl_bits[N-1];
            rises    = 0;
            mosi_cap = '0;
            if (seen_frame && gap_run < gap_min) gap_min = gap_run;
            seen_frame = 1;
        end else if (!bus.SPI_SSEL && sck_prev && !bus.SPI_SCK) begin
            sl_idx++;
            bus.SPI_MISO = (sl_idx < N) ? sl_bits[N-1-sl_idx] : 1'b0;
        end
        if (!sck_prev && bus.SPI_SCK) begin
            rises++;
            mosi_cap = {mosi_cap[N-2:0], bus.SPI_MOSI};
        end
        if (bus.SPI_SSEL) gap_run++; else gap_run = 0;
        ssel_prev = bus.SPI_SSEL;
        sck_prev  = bus.SPI_SCK;
    end

    // Frame timeline model: k counts edges since the accepting edge.
    logic         st_s = 1'b0;
    logic [N-1:0] tx_s = '0, rs_s = '0, txm = '0, rsm = '0, exp_rx = '0;
    logic         exp_ok = 1'b0;
    bit           in_frame = 0;
    int           k = 0;
    int           done_cnt = 0;

    always @(posedge clk) begin
        st_s = bus.start;
        tx_s = bus.tx_data;
        rs_s = rsp_next;
    end

    always @(negedge clk) begin
        logic e_ssel, e_sck, e_mosi, e_busy, e_done;
        int u;
        e_ssel = 1'b1; e_sck = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (!rst_n) begin
            in_frame = 0;
            k        = 0;
            exp_rx   = '0;
            exp_ok   = 1'b0;
        end else begin
            if (in_frame) begin
                k++;
                if (k == F + G) in_frame = 0;
            end else if (st_s) begin
                in_frame = 1;
                k   = 0;
                txm = tx_s;
                rsm = rs_s;
            end
            if (in_frame) begin
                e_busy = 1'b1;
                if (k < S) begin
                    e_ssel = 1'b0;
                    e_mosi = txm[N-1];
                end else if (k < S + 2*CD*N) begin
                    u      = k - S;
                    e_ssel = 1'b0;
                    e_sck  = ((u % (2*CD)) >= CD);
                    e_mosi = txm[N-1-(u / (2*CD))];
                end else if (k < F) begin
                    e_ssel = 1'b0;
                end else if (k == F) begin
                    e_done = 1'b1;
                    exp_rx = rsm;
                    exp_ok = ((rsm >> (N-32)) == N'(MSGID));
                end
            end
        end
        if (bus.done) done_cnt++;
        chk("pins{ssel,sck,mosi,busy,done,rx_ok}",
            {122'd0, bus.SPI_SSEL, bus.SPI_SCK, bus.SPI_MOSI, bus.busy, bus.done, bus.rx_ok},
            {122'd0, e_ssel, e_sck, e_mosi, e_busy, e_done, exp_ok});
        chk("rx_data", 128'(bus.rx_data), 128'(exp_rx));
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 128'(bus.busy), 128'd0);
    endtask

    task automatic run_frame(input logic [N-1:0] tx, input logic [N-1:0] rsp, input bit jitter);
        int n = 0;
        int d0;
        @(negedge clk);
        d0 = done_cnt;
        bus.tx_data = tx;
        rsp_next    = rsp;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        while (!bus.done && n < 1200) begin
            @(negedge clk);
            n++;
            if (jitter) begin
                bus.start   = ($urandom_range(0, 1) == 1);
                bus.tx_data = {$urandom(), $urandom()};
            end
        end
        bus.start = 1'b0;
        chk("done_seen", 128'(bus.done), 128'd1);
        wait_idle();
        chk("frames_per_start", 128'(done_cnt - d0), 128'd1);
    endtask

    initial begin
        int lat;
        int d0;
        int n;
        logic [N-1:0] t, r;
        bus.start    = 1'b0;
        bus.tx_data  = '0;
        bus.SPI_MISO = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ssel", 128'(bus.SPI_SSEL), 128'd1);
        chk("rst_sck",  128'(bus.SPI_SCK),  128'd0);
        chk("rst_mosi", 128'(bus.SPI_MOSI), 128'd0);
        chk("rst_busy", 128'(bus.busy),     128'd0);
        chk("rst_done", 128'(bus.done),     128'd0);
        chk("rst_rx",   128'(bus.rx_data),  128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Known frame: latency, MOSI order, edge count, loopback payload.
        bus.tx_data = 64'h74697277_DEADBEEF;
        rsp_next    = 64'h74697277_12345678;
        bus.start   = 1'b1;
        lat = 0;
        @(posedge clk); lat++;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && lat < 2000) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        chk("latency", 128'(lat), 128'd521);
        chk("mosi_bits", 128'(mosi_cap), 128'(64'h74697277_DEADBEEF));
        chk("sck_rises", 128'(rises), 128'd64);
        chk("rx_known", 128'(bus.rx_data), 128'(64'h74697277_12345678));
        chk("rx_ok_known", 128'(bus.rx_ok), 128'd1);
        wait_idle();

        run_frame({$urandom(), $urandom()}, 64'h00000000_00000001, 1'b0);
        chk("rx_bad", 128'(bus.rx_data), 128'd1);
        chk("rx_ok_bad", 128'(bus.rx_ok), 128'd0);

        for (int i = 0; i < 6; i++) begin
            t = {$urandom(), $urandom()};
            r = {$urandom(), $urandom()};
            if (i % 2 == 0) r[N-1 -: 32] = MSGID;
            run_frame(t, r, 1'b1);
            chk("rand_mosi", 128'(mosi_cap), 128'(t));
        end

        // start held high: 1600 accepting edges at period F+G+1 give 4 frames.
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        gap_min = 1000;
        seen_frame = 0;
        rsp_next = {MSGID, 32'hCAFEF00D};
        bus.tx_data = {$urandom(), $urandom()};
        bus.start = 1'b1;
        repeat (1600) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        chk("b2b_frames", 128'(done_cnt - d0), 128'd4);
        chk("b2b_gap_ge", 128'(gap_min >= G), 128'd1);
        chk("b2b_gap", 128'(gap_min), 128'(G + 1));

        // Abort after 20 SCK rising edges.
        @(negedge clk);
        d0 = done_cnt;
        bus.tx_data = {$urandom(), $urandom()};
        rsp_next = {$urandom(), $urandom()};
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (rises < 20 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach20", 128'(rises), 128'd20);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ssel", 128'(bus.SPI_SSEL), 128'd1);
        chk("abort_sck",  128'(bus.SPI_SCK),  128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 128'(done_cnt - d0), 128'd0);

        t = {$urandom(), $urandom()};
        run_frame(t, {MSGID, 32'h0BADC0DE}, 1'b0);
        chk("post_rst_rx", 128'(bus.rx_data), 128'({MSGID, 32'h0BADC0DE}));
        chk("post_rst_mosi", 128'(mosi_cap), 128'(t));
        chk("post_rst_rises", 128'(rises), 128'd64);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
